// File: rtl/key_event_ctrl.sv
// -----------------------------------------------------------------------------
// key_event_ctrl
//
// Front-panel key classifier for the DDS signal generator. Turns one debounced,
// active-low key level into three single-cycle events (short press, long press,
// auto-repeat) and keeps a waveform-select index that advances on every short
// press.
//
// Parameters:
//   T_LONG    hold time in clk cycles that qualifies a long press (2..2^26-1)
//   T_RPT     auto-repeat period in clk cycles after a long press (2..2^26-1)
//   WAVE_NUM  number of selectable waveforms, wave_sel wraps at WAVE_NUM-1 (1..4)
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous, active-low reset
//   key_n        debounced key level, 0 = pressed, already synchronous to clk
//   short_pulse  one-cycle pulse, press released before T_LONG
//   long_pulse   one-cycle pulse, press held for T_LONG
//   rpt_pulse    one-cycle pulse every T_RPT cycles while held after long press
//   key_held     high while the FSM is not IDLE
//   wave_sel     current waveform index
//
// Build option:
//   KEY_REPEAT_EN  when defined, HOLD generates auto-repeat pulses; otherwise
//                  rpt_pulse stays 0 and HOLD only waits for release.
// -----------------------------------------------------------------------------
module key_event_ctrl #(
  parameter logic [25:0] T_LONG   = 26'd50_000_000,
  parameter logic [25:0] T_RPT    = 26'd10_000_000,
  parameter logic [2:0]  WAVE_NUM = 3'd4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_n,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic       rpt_pulse,
  output logic       key_held,
  output logic [1:0] wave_sel
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [25:0] LONG_LAST = T_LONG - 26'd1;
  localparam logic [1:0]  WAVE_LAST = 2'(WAVE_NUM - 3'd1);

`ifdef KEY_REPEAT_EN
  localparam logic [25:0] RPT_LAST = T_RPT - 26'd1;
`else
  // The repeat period has no meaning without auto-repeat.
  logic unused_t_rpt;
  assign unused_t_rpt = ^T_RPT;
`endif

  state_t      state;
  logic        key_d;
  logic [25:0] cnt;
  logic        press_edge;

  // key_d resets to 1, so a key already held at reset release is seen as a
  // fresh press on the first clock edge.
  assign press_edge = key_d & ~key_n;

  // Release is tested before the long/repeat terminal counts so that a
  // release sampled on the same edge always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      key_d       <= 1'b1;
      cnt         <= 26'd0;
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
      rpt_pulse   <= 1'b0;
      key_held    <= 1'b0;
      wave_sel    <= 2'd0;
    end else begin
      key_d       <= key_n;
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
      rpt_pulse   <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= 26'd0;
          if (press_edge) begin
            state    <= PRESS;
            key_held <= 1'b1;
          end
        end
        PRESS: begin
          if (key_n) begin
            short_pulse <= 1'b1;
            wave_sel    <= (wave_sel == WAVE_LAST) ? 2'd0 : wave_sel + 2'd1;
            state       <= IDLE;
            key_held    <= 1'b0;
            cnt         <= 26'd0;
          end else if (cnt == LONG_LAST) begin
            long_pulse <= 1'b1;
            cnt        <= 26'd0;
            state      <= HOLD;
          end else begin
            cnt <= cnt + 26'd1;
          end
        end
        HOLD: begin
          if (key_n) begin
            state    <= IDLE;
            key_held <= 1'b0;
            cnt      <= 26'd0;
          end else begin
`ifdef KEY_REPEAT_EN
            if (cnt == RPT_LAST) begin
              rpt_pulse <= 1'b1;
              cnt       <= 26'd0;
            end else begin
              cnt <= cnt + 26'd1;
            end
`else
            cnt <= 26'd0;
`endif
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= 26'd0;
          key_held <= 1'b0;
        end
      endcase
    end
  end

endmodule
